video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL have these parameters:
- H_ACTIVE, default 640: visible pixels per line
- H_FP, default 16: horizontal front porch, in pixels
- H_SYNC, default 96: hsync width, in pixels
- H_BP, default 48: horizontal back porch, in pixels
- V_ACTIVE, default 480: visible lines per frame
- V_FP, default 10: vertical front porch, in lines
- V_SYNC, default 2: vsync width, in lines
- V_BP, default 33: vertical back porch, in lines
- HS_POL, default 1: hSync active level (1 = active-high)
- VS_POL, default 1: vSync active level (1 = active-high)
- CNT_W, default 12: counter width, in bits
- FCNT_W, default 8: frame counter width, in bits

REQ-002 The block SHALL have these ports:
- pixel_clk, input, 1: pixel clock; every flop is clocked on its rising edge
- reset, input, 1: synchronous, active-high reset
- ce, input, 1: pixel clock enable; when low, all state holds
- hSync, output, 1: horizontal sync, driven at HS_POL during the sync interval
- vSync, output, 1: vertical sync, driven at VS_POL during the sync interval
- VDE, output, 1: video data enable (active area)
- counterX, output, CNT_W: X coordinate of the current pixel
- counterY, output, CNT_W: Y coordinate of the current pixel
- line_start, output, 1: one-cycle strobe at X=0 of every line
- frame_start, output, 1: one-cycle strobe at X=0, Y=0
- frame_cnt, output, FCNT_W: count of completed frames, wrapping

Function
REQ-003 Derived constants SHALL be H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-004 Internal counters h_cnt and v_cnt SHALL advance only on cycles where ce=1.
REQ-005 h_cnt SHALL count 0..H_TOTAL-1 and wrap to 0.
REQ-006 v_cnt SHALL increment when h_cnt wraps, count 0..V_TOTAL-1, and wrap to 0 when h_cnt and v_cnt wrap together.
REQ-007 On the cycle both counters wrap, frame_cnt SHALL increment modulo 2^FCNT_W.
REQ-008 All outputs SHALL be registered and updated only when ce=1, so that they reflect the counter state of the previous enabled cycle (latency of 1 enabled cycle, all outputs mutually aligned).
REQ-009 counterX SHALL equal h_cnt and counterY SHALL equal v_cnt, with their registered timing.
REQ-010 hSync SHALL be HS_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, and ~HS_POL otherwise.
REQ-011 vSync SHALL be VS_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, and ~VS_POL otherwise; vSync SHALL change on line boundaries only.
REQ-012 VDE SHALL be 1 exactly when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-013 line_start SHALL be 1 exactly when h_cnt == 0.
REQ-014 frame_start SHALL be 1 exactly when h_cnt == 0 and v_cnt == 0.
REQ-015 Strobes SHALL hold their value while ce=0 and SHALL clear on the next enabled cycle, so each strobe spans exactly one enabled cycle.
REQ-016 All comparisons SHALL be unsigned at CNT_W bits.
REQ-017 CNT_W SHALL be large enough to hold both H_TOTAL-1 and V_TOTAL-1; otherwise elaboration SHALL fail through a generate-time check.
REQ-018 Degenerate porches (H_FP, H_BP, V_FP or V_BP equal to 0) SHALL be supported without glitches.

Reset
REQ-019 When reset=1 at a rising edge, regardless of ce: h_cnt, v_cnt, counterX, counterY, VDE and frame_cnt SHALL go to 0; hSync SHALL go to ~HS_POL; vSync SHALL go to ~VS_POL; line_start and frame_start SHALL go to 0.
REQ-020 Reset asserted mid-frame SHALL abort the frame immediately, with no partial strobe.
REQ-021 On the first enabled cycle after reset release, the outputs SHALL present X=0, Y=0, with line_start=1, frame_start=1 and VDE=1.

Verification
REQ-022 Defaults, ce=1, reset for 3 cycles then released: first output cycle shows counterX=0, counterY=0, VDE=1, frame_start=1; hSync high for exactly 96 cycles, starting at counterX=656; line period is 800 cycles.
REQ-023 Defaults, run 2 frames: frame_start period is 420000 cycles; vSync is high across counterY=490..491 (1600 cycles); frame_cnt goes 0->1->2; VDE count per frame is 307200.
REQ-024 ce toggled 1,0,1,0: counters advance once per two clocks; each line_start pulse lasts 2 clocks; hSync width is 192 clocks.
REQ-025 HS_POL=0, VS_POL=0: after reset hSync=vSync=1; both pulse low at the same positions as in REQ-022 and REQ-023.
REQ-026 Reset asserted at counterX=700, counterY=300 for 1 cycle: next enabled cycle shows the reset values of REQ-019, and the following enabled cycle shows X=0, Y=0, frame_start=1, with frame_cnt held at 0.
REQ-027 FCNT_W=2, run 5 frames: frame_cnt sequence is 0,1,2,3,0,1 (wrap).

Source files
------------

// File: rtl/video_timing_gen.sv
// Video timing generator: free-running pixel/line counters with registered
// sync, data-enable, coordinate, strobe and frame-count outputs. Every output
// reflects the counter state of the previous enabled cycle, so all of them
// line up with each other.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CNT_W    = 12,
    parameter int FCNT_W   = 8
) (
    input  logic              pixel_clk,
    input  logic              reset,
    input  logic              ce,
    output logic              hSync,
    output logic              vSync,
    output logic              VDE,
    output logic [CNT_W-1:0]  counterX,
    output logic [CNT_W-1:0]  counterY,
    output logic              line_start,
    output logic              frame_start,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Both terminal counts must be representable in the counter width.
    generate
        if ((longint'(H_TOTAL) - 1) >= (longint'(1) << CNT_W) ||
            (longint'(V_TOTAL) - 1) >= (longint'(1) << CNT_W)) begin : g_cnt_w_too_small
            $fatal(1, "video_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
        end
    endgenerate

    // Window bounds are kept as inclusive last positions so that a zero back
    // porch (window ending exactly at the total) never needs a value that
    // would overflow CNT_W bits.
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HA_LAST    = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] VA_LAST    = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0]  h_cnt;
    logic [CNT_W-1:0]  v_cnt;
    logic [FCNT_W-1:0] f_cnt;

    logic h_wrap;
    logic v_wrap;
    logic hs_win;
    logic vs_win;
    logic de_win;

    // Decode of the current counter position, registered into the outputs.
    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        v_wrap = (v_cnt == V_LAST);
        hs_win = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
        vs_win = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
        de_win = (h_cnt <= HA_LAST) && (v_cnt <= VA_LAST);
    end

    // Pixel/line counters and completed-frame count; advance only when enabled.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
            f_cnt <= '0;
        end else if (ce) begin
            if (h_wrap) begin
                h_cnt <= '0;
                if (v_wrap) begin
                    v_cnt <= '0;
                    f_cnt <= f_cnt + FCNT_W'(1);
                end else begin
                    v_cnt <= v_cnt + CNT_W'(1);
                end
            end else begin
                h_cnt <= h_cnt + CNT_W'(1);
            end
        end
    end

    // Output registers: one enabled cycle behind the counters, held while ce=0.
    // frame_cnt goes through the same stage so it changes with frame_start.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            hSync       <= ~HS_POL;
            vSync       <= ~VS_POL;
            VDE         <= 1'b0;
            counterX    <= '0;
            counterY    <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else if (ce) begin
            hSync       <= hs_win ? HS_POL : ~HS_POL;
            vSync       <= vs_win ? VS_POL : ~VS_POL;
            VDE         <= de_win;
            counterX    <= h_cnt;
            counterY    <= v_cnt;
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            frame_cnt   <= f_cnt;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default-parameter instance and a small,
// inverted-polarity instance with zero porches and a 2-bit frame counter,
// both driven by the same reset/ce and compared every clock against an
// arithmetic reference model of the display position.
module tb_video_timing_gen;

    logic pixel_clk = 1'b0;
    logic reset = 1'b1;
    logic ce = 1'b1;

    // clock / reset block
    always #5 pixel_clk = ~pixel_clk;

    logic        a_hs, a_vs, a_vde, a_ls, a_fs;
    logic [11:0] a_x, a_y;
    logic [7:0]  a_fc;

    logic        b_hs, b_vs, b_vde, b_ls, b_fs;
    logic [3:0]  b_x, b_y;
    logic [1:0]  b_fc;

    video_timing_gen dut_a (
        .pixel_clk(pixel_clk), .reset(reset), .ce(ce),
        .hSync(a_hs), .vSync(a_vs), .VDE(a_vde),
        .counterX(a_x), .counterY(a_y),
        .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc)
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(0), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(0),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(4), .FCNT_W(2)
    ) dut_b (
        .pixel_clk(pixel_clk), .reset(reset), .ce(ce),
        .hSync(b_hs), .vSync(b_vs), .VDE(b_vde),
        .counterX(b_x), .counterY(b_y),
        .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc)
    );

    int total = 0;
    int bad   = 0;

    int pos_a = 0;
    int pos_b = 0;
    logic [63:0] exp_a = '0;
    logic [63:0] exp_b = '0;

    // Common packing of all outputs into one comparable word.
    function automatic logic [63:0] pack(bit hs, bit vs, bit vde, bit ls, bit fs,
                                         int x, int y, int fc);
        logic [63:0] v;
        v = '0;
        v[36] = hs;
        v[35] = vs;
        v[34] = vde;
        v[33] = ls;
        v[32] = fs;
        v[31:20] = x[11:0];
        v[19:8]  = y[11:0];
        v[7:0]   = fc[7:0];
        return v;
    endfunction

    // Reference: expected outputs when the k-th enabled cycle since reset is shown.
    function automatic logic [63:0] model_vec(int k, int ha, int hf, int hsw, int hb,
                                              int va, int vf, int vsw, int vb,
                                              bit hp, bit vp, int fw);
        int ht, vt, x, y, fc;
        bit hs, vs, vde;
        ht  = ha + hf + hsw + hb;
        vt  = va + vf + vsw + vb;
        x   = k % ht;
        y   = (k / ht) % vt;
        fc  = (k / (ht * vt)) % (1 << fw);
        hs  = (x >= ha + hf && x < ha + hf + hsw) ? hp : !hp;
        vs  = (y >= va + vf && y < va + vf + vsw) ? vp : !vp;
        vde = (x < ha) && (y < va);
        return pack(hs, vs, vde, x == 0, (x == 0) && (y == 0), x, y, fc);
    endfunction

    function automatic logic [63:0] model_a(int k);
        return model_vec(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b1, 8);
    endfunction

    function automatic logic [63:0] model_b(int k);
        return model_vec(k, 8, 0, 3, 2, 5, 1, 2, 0, 1'b0, 1'b0, 2);
    endfunction

    function automatic logic [63:0] act_a();
        return pack(a_hs, a_vs, a_vde, a_ls, a_fs, int'(a_x), int'(a_y), int'(a_fc));
    endfunction

    function automatic logic [63:0] act_b();
        return pack(b_hs, b_vs, b_vde, b_ls, b_fs, int'(b_x), int'(b_y), int'(b_fc));
    endfunction

    // scoreboard compare
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp_v, $time);
        end
    endtask

    // driver: one clock, advance the model, then compare both instances
    task automatic step();
        @(posedge pixel_clk);
        if (reset) begin
            pos_a = 0;
            pos_b = 0;
            exp_a = pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
            exp_b = pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        end else if (ce) begin
            exp_a = model_a(pos_a);
            exp_b = model_b(pos_b);
            pos_a++;
            pos_b++;
        end
        #1;
        chk("cyc_a", act_a(), exp_a);
        chk("cyc_b", act_b(), exp_b);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        ce = 1'b1;
        for (int i = 0; i < n; i++) step();
        reset = 1'b0;
    endtask

    typedef struct {
        int k;
        int x;
        int y;
        bit hs;
        bit vde;
        bit ls;
        bit fs;
    } tv_t;

    tv_t tv[12];

    initial begin
        int hs_cnt, ls_clk, vde_cnt, vs_cnt, bhs_cnt, last_fs;
        logic [1:0] fc_q[$];
        int fs_step[$];
        int exp_fc[6];

        // expected positions along the first two lines of the default timing
        tv[0]  = '{0,    0,   0, 1'b0, 1'b1, 1'b1, 1'b1};
        tv[1]  = '{1,    1,   0, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[2]  = '{639,  639, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[3]  = '{640,  640, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{655,  655, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[5]  = '{656,  656, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[6]  = '{751,  751, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[7]  = '{752,  752, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{799,  799, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[9]  = '{800,  0,   1, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[10] = '{1440, 640, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[11] = '{1456, 656, 1, 1'b1, 1'b0, 1'b0, 1'b0};

        // reset state, both polarities
        do_reset(3);
        chk("rst_a", act_a(), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0));
        chk("rst_b", act_b(), pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0));

        // table-driven walk along the default line; also count hSync width
        hs_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            for (int g = 0; g < 2000 && (pos_a - 1) < tv[i].k; g++) begin
                step();
                if (pos_a - 1 < 800) hs_cnt += int'(a_hs);
            end
            chk($sformatf("tv%0d", i),
                pack(a_hs, 1'b0, a_vde, a_ls, a_fs, int'(a_x), int'(a_y), 0),
                pack(tv[i].hs, 1'b0, tv[i].vde, tv[i].ls, tv[i].fs, tv[i].x, tv[i].y, 0));
        end
        chk("hs_width_a", 64'(hs_cnt), 64'd96);

        // ce toggled 1,0: strobes and sync stretch to two clocks
        do_reset(2);
        hs_cnt = 0;
        ls_clk = 0;
        for (int i = 0; i < 1600; i++) begin
            ce = (i % 2 == 0);
            step();
            hs_cnt += int'(a_hs);
            ls_clk += int'(a_ls);
        end
        chk("ce_hs_clocks", 64'(hs_cnt), 64'd192);
        chk("ce_ls_clocks", 64'(ls_clk), 64'd2);
        chk("ce_pos", 64'({a_x, a_y}), 64'({12'd799, 12'd0}));

        // reset mid-frame on the small timing: frame 1, x=10 y=3
        do_reset(1);
        for (int i = 0; i < 154; i++) step();
        chk("pre_rst_b", 64'({b_x, b_y, b_fc}), 64'({4'd10, 4'd3, 2'd1}));
        reset = 1'b1;
        step();
        chk("mid_rst_b", act_b(), pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0));
        reset = 1'b0;
        step();
        chk("post_rst_b", 64'({b_x, b_y, b_fs, b_fc}), 64'({4'd0, 4'd0, 1'b1, 2'd0}));

        // six frames on the small timing: frame_cnt wrap, period, per-frame counts
        do_reset(1);
        vde_cnt = 0;
        vs_cnt = 0;
        bhs_cnt = 0;
        for (int i = 0; i < 6 * 104; i++) begin
            step();
            if (b_fs) begin
                fc_q.push_back(b_fc);
                fs_step.push_back(i);
            end
            if (i < 104) begin
                vde_cnt += int'(b_vde);
                vs_cnt += int'(!b_vs);
            end
            if (i < 13) bhs_cnt += int'(!b_hs);
        end
        chk("b_vde_per_frame", 64'(vde_cnt), 64'd40);
        chk("b_vs_per_frame", 64'(vs_cnt), 64'd26);
        chk("b_hs_per_line", 64'(bhs_cnt), 64'd3);
        chk("b_fs_count", 64'(fc_q.size()), 64'd6);
        exp_fc = '{0, 1, 2, 3, 0, 1};
        last_fs = -1;
        for (int i = 0; i < fc_q.size() && i < 6; i++) begin
            chk($sformatf("b_fc%0d", i), 64'(fc_q[i]), 64'(exp_fc[i]));
            if (i > 0) chk($sformatf("b_fs_period%0d", i), 64'(fs_step[i] - last_fs), 64'd104);
            last_fs = fs_step[i];
        end

        // random ce and occasional reset, checked cycle by cycle
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            ce = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
